// File: rtl/vga_timing_prog.sv
// Programmable VGA timing generator: position counters, sync/active decode, and a
// frame-aligned timing reload. Define VGA_TIMING_FRAME_CNT_EN to build in the frame counter.
module vga_timing_prog #(
  parameter int CNT_W         = 10,
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [4*CNT_W-1:0] cfg_h,
  input  logic [4*CNT_W-1:0] cfg_v,
  output logic               cfg_err,
  input  logic [CNT_W-1:0]   line_match,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               v_begin,
  output logic               line_irq,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic [15:0]        frame_cnt
);
  localparam int SW = CNT_W + 2;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;
  localparam logic [SW-1:0] MAX_TOTAL = SW'(1) << CNT_W;

  // Field index: 0 active, 1 front porch, 2 sync, 3 back porch.
  logic [CNT_W-1:0] h_tim_reg [4];
  logic [CNT_W-1:0] v_tim_reg [4];
  logic [CNT_W-1:0] h_shd_reg [4];
  logic [CNT_W-1:0] v_shd_reg [4];
  logic [CNT_W-1:0] cfg_h_f   [4];
  logic [CNT_W-1:0] cfg_v_f   [4];
  logic [CNT_W-1:0] h_def     [4];
  logic [CNT_W-1:0] v_def     [4];

  logic [CNT_W-1:0] hpos_reg, vpos_reg;
  logic [0:0]       state_reg;
  logic             cfg_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fields
      assign cfg_h_f[gi] = cfg_h[(4-gi)*CNT_W-1 -: CNT_W];
      assign cfg_v_f[gi] = cfg_v[(4-gi)*CNT_W-1 -: CNT_W];
    end
  endgenerate

  assign h_def[0] = CNT_W'(H_ACTIVE);
  assign h_def[1] = CNT_W'(H_FRONT_PORCH);
  assign h_def[2] = CNT_W'(H_SYNC);
  assign h_def[3] = CNT_W'(H_BACK_PORCH);
  assign v_def[0] = CNT_W'(V_ACTIVE);
  assign v_def[1] = CNT_W'(V_FRONT_PORCH);
  assign v_def[2] = CNT_W'(V_SYNC);
  assign v_def[3] = CNT_W'(V_BACK_PORCH);

  function automatic logic [SW-1:0] total4(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b,
                                           input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
    return SW'(a) + SW'(b) + SW'(c) + SW'(d);
  endfunction

  logic [SW-1:0] ht, vt, ht_cfg, vt_cfg;
  logic [SW-1:0] hs_start, hs_end, vs_start, vs_end;
  logic          h_end, v_end, cfg_ok;

  assign ht     = total4(h_tim_reg[0], h_tim_reg[1], h_tim_reg[2], h_tim_reg[3]);
  assign vt     = total4(v_tim_reg[0], v_tim_reg[1], v_tim_reg[2], v_tim_reg[3]);
  assign ht_cfg = total4(cfg_h_f[0], cfg_h_f[1], cfg_h_f[2], cfg_h_f[3]);
  assign vt_cfg = total4(cfg_v_f[0], cfg_v_f[1], cfg_v_f[2], cfg_v_f[3]);

  assign h_end = (SW'(hpos_reg) == ht - SW'(1));
  assign v_end = (SW'(vpos_reg) == vt - SW'(1));

  assign cfg_ok = (cfg_h_f[0] != '0) && (cfg_h_f[2] != '0) &&
                  (cfg_v_f[0] != '0) && (cfg_v_f[2] != '0) &&
                  (ht_cfg <= MAX_TOTAL) && (vt_cfg <= MAX_TOTAL);

  assign hs_start = SW'(h_tim_reg[0]) + SW'(h_tim_reg[1]);
  assign hs_end   = hs_start + SW'(h_tim_reg[2]);
  assign vs_start = SW'(v_tim_reg[0]) + SW'(v_tim_reg[1]);
  assign vs_end   = vs_start + SW'(v_tim_reg[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_reg    <= '0;
      vpos_reg    <= '0;
      state_reg   <= ST_IDLE;
      cfg_err_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        h_tim_reg[i] <= h_def[i];
        v_tim_reg[i] <= v_def[i];
        h_shd_reg[i] <= '0;
        v_shd_reg[i] <= '0;
      end
    end else begin
      cfg_err_reg <= 1'b0;
      if (state_reg == ST_IDLE && cfg_valid) begin
        if (cfg_ok) begin
          for (int i = 0; i < 4; i++) begin
            h_shd_reg[i] <= cfg_h_f[i];
            v_shd_reg[i] <= cfg_v_f[i];
          end
          state_reg <= ST_PENDING;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end
      if (clk_en) begin
        if (h_end) begin
          hpos_reg <= '0;
          if (v_end) begin
            vpos_reg <= '0;
            // New timing lands exactly on the frame boundary, so no frame is mixed.
            if (state_reg == ST_PENDING) begin
              for (int i = 0; i < 4; i++) begin
                h_tim_reg[i] <= h_shd_reg[i];
                v_tim_reg[i] <= v_shd_reg[i];
              end
              state_reg <= ST_IDLE;
            end
          end else begin
            vpos_reg <= vpos_reg + CNT_W'(1);
          end
        end else begin
          hpos_reg <= hpos_reg + CNT_W'(1);
        end
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (clk_en && h_end && v_end) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end
  assign frame_cnt = frame_cnt_reg;
`else
  assign frame_cnt = '0;
`endif

  assign hpos      = hpos_reg;
  assign vpos      = vpos_reg;
  assign cfg_ready = (state_reg == ST_IDLE);
  assign cfg_err   = cfg_err_reg;
  assign active    = (hpos_reg < h_tim_reg[0]) && (vpos_reg < v_tim_reg[0]);
  assign hsync     = (SW'(hpos_reg) >= hs_start && SW'(hpos_reg) < hs_end) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync     = (SW'(vpos_reg) >= vs_start && SW'(vpos_reg) < vs_end) ? VSYNC_POL : ~VSYNC_POL;
  assign v_begin   = (hpos_reg == '0) && (vpos_reg == '0);
  assign line_irq  = clk_en && (hpos_reg == h_tim_reg[0] - CNT_W'(1)) && (vpos_reg == line_match);

endmodule
